decode_out_capture_fifo: RTL
============================

Name: decode_out_capture_fifo

Overview:
- Synthesizable capture buffer for the LC3 decode-stage output bus. Samples w_control, mem_control, e_control, IR and npc_out on qualified clock edges and stamps each record with a free-running cycle count.
- Queues records in a DEPTH-entry FIFO drained through a valid/ready port.
- Parametrised successor to the per-transaction decode output monitor: configurable widths and depth, overflow accounting and flush.
- Sits beside the decode stage; feeds scoreboards or a trace port.

Parameters:
DATA_W, 16, width of IR, npc_out and their output copies
ECTRL_W, 6, width of e_control
DEPTH, 8, FIFO entries; power of two, >= 2
TS_W, 32, timestamp counter width
DROP_W, 16, width of the saturating drop counter

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
capture_en  input  1  global capture enable
in_valid  input  1  decode output qualifier (enable_decode)
w_control  input  1  decode writeback control
mem_control  input  1  decode memory control
e_control  input  ECTRL_W  decode execute control
IR  input  DATA_W  decoded instruction
npc_out  input  DATA_W  next PC from decode
flush  input  1  synchronous FIFO clear
out_valid  output  1  head record available
out_ready  input  1  consumer accepts head
out_w_control  output  1  head record field
out_mem_control  output  1  head record field
out_e_control  output  ECTRL_W  head record field
out_IR  output  DATA_W  head record field
out_npc  output  DATA_W  head record field
out_ts  output  TS_W  cycle count at sample
level  output  $clog2(DEPTH+1)  current occupancy
overflow  output  1  sticky: at least one record dropped
drop_cnt  output  DROP_W  saturating count of dropped records

Behaviour:
- One clock. Reset is asynchronous and active-high: asserting reset immediately clears the following, independent of clock:
  - ts, pointers and level
  - out_valid, all out_* fields, overflow and drop_cnt
- ts:
  - Increments every clock while reset is low.
  - Wraps from 2^TS_W-1 to 0.
  - The record stamp is the ts value present in the cycle the sample is taken.
- push = capture_en & in_valid & !reset. Fields are sampled at the rising edge.
- pop = out_valid & out_ready.
- Latency: a record pushed at edge N is visible with out_valid=1 at edge N (registered). The consumer sees it in the cycle after the sample cycle.
- Head fields are stable while out_valid=1 and out_ready=0.
- out_* fields are 0 when the FIFO is empty.
- FIFO order is strict: first in, first out.
- Read and write pointers are log2(DEPTH) bits and wrap naturally.
- level changes:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on push and pop together.
- Full (level == DEPTH):
  - push with no pop: record dropped, overflow set, drop_cnt incremented.
  - drop_cnt saturates at 2^DROP_W-1.
  - push together with pop: push accepted, no drop.
- Empty: out_ready is ignored and there is no underflow.
- flush, synchronous and highest priority below reset:
  - Clears level, pointers, out_valid and overflow.
  - ts and drop_cnt are kept.
  - A push in the flush cycle is discarded and not counted as a drop.
  - A pop in the flush cycle is ignored.
- Reset mid-burst: all queued records are lost. Capture resumes on the first edge after reset deasserts.

Optional Feature:
- Macro: DECODE_MON_CHANGE_FILTER_EN.
- When defined:
  - A last-accepted register holds {w_control, mem_control, e_control, IR, npc_out}.
  - A push whose fields equal the last-accepted register is suppressed: no write and no drop count.
  - The register is invalidated by reset and flush, so the first sample after either is always accepted.
  - A dropped (full) sample does not update the register.
- When undefined: every qualified cycle is pushed, and no compare logic exists.

Test Plan (DEPTH=4, DATA_W=16, ECTRL_W=6, TS_W=16):
- Basic push and pop:
  - Stimulus: reset release; at ts=5 drive in_valid=1, IR=16'h1234, npc_out=16'h3001, e_control=6'h2A, w=1, mem=0; then out_ready=1.
  - Response: next cycle out_valid=1, out_ts=5 and matching fields; after the pop, out_valid=0 and level=0.
- Overflow:
  - Stimulus: 5 consecutive pushes with IR=16'h0001..16'h0005 and out_ready=0.
  - Response: level=4, overflow=1, drop_cnt=1; drain yields 0001..0004 in order.
- Push and pop while full:
  - Stimulus: full FIFO, push IR=16'h00AA with out_ready=1.
  - Response: level stays 4, drop_cnt unchanged, 16'h00AA appears as the 4th record after the pop.
- Flush with push:
  - Stimulus: 3 records queued, flush=1 with push.
  - Response: next cycle level=0, out_valid=0, overflow=0; drop_cnt and ts continue.
- Asynchronous reset:
  - Stimulus: assert reset mid-cycle with 2 records queued.
  - Response: out_valid, level, ts and drop_cnt are 0 before the next clock edge.
- Timestamp wrap and change filter:
  - Stimulus (TS_W=4): push at ts=15 and ts=0.
  - Response: out_ts values are 15 then 0.
  - With DECODE_MON_CHANGE_FILTER_EN: 3 identical pushes give level=1 and drop_cnt=0.

Source files
------------

// File: rtl/decode_out_capture_fifo.sv
// Capture FIFO for the LC3 decode-stage output bus: timestamped records drained via valid/ready.
// Optional duplicate-sample suppression is enabled by defining DECODE_MON_CHANGE_FILTER_EN.
module decode_out_capture_fifo #(
    parameter int DATA_W  = 16,
    parameter int ECTRL_W = 6,
    parameter int DEPTH   = 8,
    parameter int TS_W    = 32,
    parameter int DROP_W  = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       capture_en,
    input  logic                       in_valid,
    input  logic                       w_control,
    input  logic                       mem_control,
    input  logic [ECTRL_W-1:0]         e_control,
    input  logic [DATA_W-1:0]          IR,
    input  logic [DATA_W-1:0]          npc_out,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_w_control,
    output logic                       out_mem_control,
    output logic [ECTRL_W-1:0]         out_e_control,
    output logic [DATA_W-1:0]          out_IR,
    output logic [DATA_W-1:0]          out_npc,
    output logic [TS_W-1:0]            out_ts,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       overflow,
    output logic [DROP_W-1:0]          drop_cnt
);
    localparam int PTR_W    = $clog2(DEPTH);
    localparam int LVL_W    = $clog2(DEPTH+1);
    localparam int SAMPLE_W = 2 + ECTRL_W + 2*DATA_W;
    localparam int REC_W    = SAMPLE_W + TS_W;

    logic [REC_W-1:0]    mem [DEPTH];
    logic [TS_W-1:0]     ts_reg;
    logic [PTR_W-1:0]    wr_ptr_reg;
    logic [PTR_W-1:0]    rd_ptr_reg;
    logic [LVL_W-1:0]    level_reg;
    logic                overflow_reg;
    logic [DROP_W-1:0]   drop_cnt_reg;

    logic [SAMPLE_W-1:0] sample;
    logic [REC_W-1:0]    head;
    logic                push;
    logic                pop;
    logic                full;
    logic                dup;
    logic                accept;
    logic                drop;

    assign sample = {w_control, mem_control, e_control, IR, npc_out};
    assign push   = capture_en & in_valid;
    assign full   = (level_reg == LVL_W'(DEPTH));
    assign pop    = out_valid & out_ready;
    // With push and pop together a full FIFO frees the head slot in the same edge.
    assign accept = push & ~dup & (~full | pop);
    assign drop   = push & ~dup & full & ~pop;

`ifdef DECODE_MON_CHANGE_FILTER_EN
    logic [SAMPLE_W-1:0] last_reg;
    logic                last_valid_reg;

    assign dup = last_valid_reg && (sample == last_reg);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_reg       <= '0;
            last_valid_reg <= 1'b0;
        end else if (flush) begin
            last_valid_reg <= 1'b0;
        end else if (accept) begin
            last_reg       <= sample;
            last_valid_reg <= 1'b1;
        end
    end
`else
    assign dup = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ts_reg       <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
            overflow_reg <= 1'b0;
            drop_cnt_reg <= '0;
        end else begin
            ts_reg <= ts_reg + TS_W'(1);
            if (flush) begin
                wr_ptr_reg   <= '0;
                rd_ptr_reg   <= '0;
                level_reg    <= '0;
                overflow_reg <= 1'b0;
            end else begin
                if (accept)
                    wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
                if (pop)
                    rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
                case ({accept, pop})
                    2'b10:   level_reg <= level_reg + LVL_W'(1);
                    2'b01:   level_reg <= level_reg - LVL_W'(1);
                    default: level_reg <= level_reg;
                endcase
                if (drop) begin
                    overflow_reg <= 1'b1;
                    if (drop_cnt_reg != {DROP_W{1'b1}})
                        drop_cnt_reg <= drop_cnt_reg + DROP_W'(1);
                end
            end
        end
    end

    // Storage carries no reset; the out_valid gate hides stale contents.
    always_ff @(posedge clock) begin
        if (accept && !flush)
            mem[wr_ptr_reg] <= {sample, ts_reg};
    end

    assign head      = mem[rd_ptr_reg];
    assign out_valid = (level_reg != '0);
    assign level     = level_reg;
    assign overflow  = overflow_reg;
    assign drop_cnt  = drop_cnt_reg;

    always_comb begin
        out_w_control   = 1'b0;
        out_mem_control = 1'b0;
        out_e_control   = '0;
        out_IR          = '0;
        out_npc         = '0;
        out_ts          = '0;
        if (out_valid)
            {out_w_control, out_mem_control, out_e_control, out_IR, out_npc, out_ts} = head;
    end
endmodule
